vit_token_concat_stream: RTL and testbench

//  Streaming token-concat engine for the ViT datapath. It inserts P stored prefix tokens (CLS/distillation) per channel slice,

---
 rtl/vit_token_concat_stream_pkg.sv | 37 +++
 rtl/vit_token_concat_stream_if.sv | 29 ++
 rtl/vit_token_concat_stream_pfx_buf.sv | 23 ++
 rtl/vit_token_concat_stream.sv | 202 ++++++++++++++++++++
 tb/tb_vit_token_concat_stream.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vit_token_concat_stream_pkg.sv
// Shared widths, state/mode enums and phase helper for the ViT token-concat stream engine.
package vit_token_concat_stream_pkg;

    localparam int DAT_DW     = 8;
    localparam int TOUT       = 32;
    localparam int BW         = DAT_DW * TOUT;
    localparam int MAX_PREFIX = 4;
    localparam int MAX_SLICES = 8;
    localparam int TOK_W      = 9;

    localparam int CNT_W      = TOK_W + 1;
    localparam int PFX_W      = $clog2(MAX_PREFIX + 1);
    localparam int SLC_W      = $clog2(MAX_SLICES + 1);
    localparam int PFX_IDX_W  = $clog2(MAX_PREFIX);
    localparam int SLC_IDX_W  = $clog2(MAX_SLICES);
    localparam int ADDR_W     = SLC_IDX_W + PFX_IDX_W;
    localparam int BUF_DEPTH  = MAX_PREFIX * MAX_SLICES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_PASS,
        ST_FIN
    } state_e;

    typedef enum logic {
        MODE_PREPEND = 1'b0,
        MODE_APPEND  = 1'b1
    } mode_e;

    // Prepend with prefixes starts each slice by emitting them; otherwise inputs go first.
    function automatic state_e first_phase(mode_e mode, logic [PFX_W-1:0] pfx);
        return (mode == MODE_PREPEND && pfx != '0) ? ST_EMIT : ST_PASS;
    endfunction

endpackage

// File: rtl/vit_token_concat_stream_if.sv
// Prefix-load, feature-input and concatenated-output streams of the token-concat engine.
interface vit_token_concat_stream_if;
    import vit_token_concat_stream_pkg::*;

    logic          pfx_valid;
    logic          pfx_ready;
    logic [BW-1:0] pfx_data;

    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;

    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          out_end;

    modport master (
        output pfx_valid, pfx_data, in_valid, in_data, out_ready,
        input  pfx_ready, in_ready, out_valid, out_data, out_last, out_end
    );

    modport slave (
        input  pfx_valid, pfx_data, in_valid, in_data, out_ready,
        output pfx_ready, in_ready, out_valid, out_data, out_last, out_end
    );

endinterface

// File: rtl/vit_token_concat_stream_pfx_buf.sv
// Prefix token register file indexed by {slice, prefix}; synchronous write, combinational read.
module vit_token_concat_stream_pfx_buf
    import vit_token_concat_stream_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BW-1:0]     wr_data_i,
    output logic [BW-1:0]     rd_data_o
);

    logic [BW-1:0] mem_q [BUF_DEPTH];

    // NOTE: storage arrays carry no reset; contents are defined only by writes.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/vit_token_concat_stream.sv
// Streaming token-concat engine: inserts P stored prefix tokens before or after the N tokens of each slice.
module vit_token_concat_stream
    import vit_token_concat_stream_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start_i,
    input  logic [TOK_W-1:0]       cfg_tok_in_i,
    input  logic [PFX_W-1:0]       cfg_prefix_i,
    input  logic [SLC_W-1:0]       cfg_slices_i,
    input  logic                   cfg_mode_i,
    input  logic                   cfg_keep_pfx_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   cfg_err_o,
    vit_token_concat_stream_if.slave bus
);

    state_e             state_q, state_d;
    logic [SLC_W-1:0]   slice_q, slice_d;
    logic [CNT_W-1:0]   tok_q, tok_d;
    logic [TOK_W-1:0]   n_q, n_d;
    logic [PFX_W-1:0]   p_q, p_d;
    logic [SLC_W-1:0]   s_q, s_d;
    mode_e              mode_q, mode_d;
    logic               out_valid_q, out_valid_d;
    logic [BW-1:0]      out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               out_end_q, out_end_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               out_load;
    logic               slice_last;
    logic               tok_last_n;
    logic               tok_last_p;
    logic               slice_end;
    logic               buf_wr_en;
    logic [ADDR_W-1:0]  buf_addr;
    logic [BW-1:0]      buf_rdata;

    assign out_load   = !out_valid_q || bus.out_ready;
    assign slice_last = (slice_q == s_q - SLC_W'(1));
    assign tok_last_n = (tok_q == CNT_W'(n_q) - CNT_W'(1));
    assign tok_last_p = (tok_q == CNT_W'(p_q) - CNT_W'(1));
    assign buf_addr   = {slice_q[SLC_IDX_W-1:0], tok_q[PFX_IDX_W-1:0]};

    vit_token_concat_stream_pfx_buf u_pfx_buf (
        .clk       (clk),
        .wr_en_i   (buf_wr_en),
        .addr_i    (buf_addr),
        .wr_data_i (bus.pfx_data),
        .rd_data_o (buf_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            slice_q     <= '0;
            tok_q       <= '0;
            n_q         <= '0;
            p_q         <= '0;
            s_q         <= '0;
            mode_q      <= MODE_PREPEND;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_end_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slice_q     <= slice_d;
            tok_q       <= tok_d;
            n_q         <= n_d;
            p_q         <= p_d;
            s_q         <= s_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_end_q   <= out_end_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        slice_d     = slice_q;
        tok_d       = tok_q;
        n_d         = n_q;
        p_d         = p_q;
        s_d         = s_q;
        mode_d      = mode_q;
        out_valid_d = out_load ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_end_d   = out_end_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        slice_end   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    if (cfg_tok_in_i == '0 || cfg_slices_i == '0 ||
                        cfg_slices_i > SLC_W'(MAX_SLICES) || cfg_prefix_i > PFX_W'(MAX_PREFIX)) begin
                        err_d = 1'b1;
                    end else begin
                        n_d     = cfg_tok_in_i;
                        p_d     = cfg_prefix_i;
                        s_d     = cfg_slices_i;
                        mode_d  = mode_e'(cfg_mode_i);
                        slice_d = '0;
                        tok_d   = '0;
                        state_d = (cfg_prefix_i != '0 && !cfg_keep_pfx_i) ? ST_LOAD
                                : first_phase(mode_e'(cfg_mode_i), cfg_prefix_i);
                    end
                end
            end
            ST_LOAD: begin
                if (bus.pfx_valid) begin
                    if (tok_last_p) begin
                        tok_d = '0;
                        if (slice_last) begin
                            slice_d = '0;
                            state_d = first_phase(mode_q, p_q);
                        end else begin
                            slice_d = slice_q + SLC_W'(1);
                        end
                    end else begin
                        tok_d = tok_q + CNT_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (out_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = buf_rdata;
                    out_last_d  = (mode_q == MODE_APPEND) && tok_last_p;
                    out_end_d   = (mode_q == MODE_APPEND) && tok_last_p && slice_last;
                    if (tok_last_p) begin
                        tok_d = '0;
                        if (mode_q == MODE_PREPEND) state_d = ST_PASS;
                        else                        slice_end = 1'b1;
                    end else begin
                        tok_d = tok_q + CNT_W'(1);
                    end
                end
            end
            ST_PASS: begin
                if (bus.in_valid && out_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.in_data;
                    out_last_d  = tok_last_n && (mode_q == MODE_PREPEND || p_q == '0);
                    out_end_d   = tok_last_n && (mode_q == MODE_PREPEND || p_q == '0) && slice_last;
                    if (tok_last_n) begin
                        tok_d = '0;
                        if (mode_q == MODE_APPEND && p_q != '0) state_d = ST_EMIT;
                        else                                    slice_end = 1'b1;
                    end else begin
                        tok_d = tok_q + CNT_W'(1);
                    end
                end
            end
            ST_FIN: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The next slice's first phase starts on the same edge, so phases run back-to-back.
        if (slice_end) begin
            if (slice_last) begin
                state_d = ST_FIN;
            end else begin
                slice_d = slice_q + SLC_W'(1);
                state_d = first_phase(mode_q, p_q);
            end
        end
    end

    always_comb begin
        busy_o        = (state_q != ST_IDLE);
        done_o        = done_q;
        cfg_err_o     = err_q;
        buf_wr_en     = (state_q == ST_LOAD) && bus.pfx_valid;
        bus.pfx_ready = (state_q == ST_LOAD);
        bus.in_ready  = (state_q == ST_PASS) && out_load;
        bus.out_valid = out_valid_q;
        bus.out_data  = out_data_q;
        bus.out_last  = out_last_q;
        bus.out_end   = out_end_q;
    end

endmodule

// File: tb/tb_vit_token_concat_stream.sv
// Directed bench for the token-concat engine: reference beat queue built from a prefix-buffer model.
module tb_vit_token_concat_stream;
    import vit_token_concat_stream_pkg::*;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
        logic          end_;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start;
    logic [TOK_W-1:0]   cfg_tok_in;
    logic [PFX_W-1:0]   cfg_prefix;
    logic [SLC_W-1:0]   cfg_slices;
    logic               cfg_mode;
    logic               cfg_keep_pfx;
    logic               busy;
    logic               done;
    logic               cfg_err;

    int n_tests = 0;
    int n_fail  = 0;
    int beats;

    logic [BW-1:0] model_buf [BUF_DEPTH];
    logic [BW-1:0] pfx_q [$];
    logic [BW-1:0] in_q [$];
    beat_t         exp_q [$];

    vit_token_concat_stream_if bus ();

    vit_token_concat_stream dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start_i    (cfg_start),
        .cfg_tok_in_i   (cfg_tok_in),
        .cfg_prefix_i   (cfg_prefix),
        .cfg_slices_i   (cfg_slices),
        .cfg_mode_i     (cfg_mode),
        .cfg_keep_pfx_i (cfg_keep_pfx),
        .busy_o         (busy),
        .done_o         (done),
        .cfg_err_o      (cfg_err),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Builds the stimulus streams and the expected output sequence for one job.
    task automatic prepare(input int n, input int p, input int s, input bit mode,
                           input bit keep, input bit pattern);
        pfx_q.delete();
        in_q.delete();
        exp_q.delete();
        if (p > 0 && !keep) begin
            for (int sl = 0; sl < s; sl++) begin
                for (int k = 0; k < p; k++) begin
                    logic [BW-1:0] d;
                    d = pattern ? BW'(sl * p + k + 'hA0) : rand_beat();
                    pfx_q.push_back(d);
                    model_buf[sl * MAX_PREFIX + k] = d;
                end
            end
        end
        for (int i = 0; i < n * s; i++) in_q.push_back(rand_beat());
        for (int sl = 0; sl < s; sl++) begin
            for (int j = 0; j < n + p; j++) begin
                beat_t b;
                if (!mode) b.data = (j < p) ? model_buf[sl * MAX_PREFIX + j] : in_q[sl * n + j - p];
                else       b.data = (j < n) ? in_q[sl * n + j] : model_buf[sl * MAX_PREFIX + j - n];
                b.last = (j == n + p - 1);
                b.end_ = b.last && (sl == s - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Starts a job and runs the streams until done, a cycle budget, or abort_at output beats.
    task automatic run_job(input int n, input int p, input int s, input bit mode, input bit keep,
                           input int rdy_pct, input int vld_pct, input int abort_at,
                           input bit noise, output int n_out);
        int  cyc = 0;
        int  total;
        bit  fin = 1'b0;
        bit  aborted = 1'b0;
        bit  err_seen = 1'b0;
        bit  pr_seen = 1'b0;
        bit  tp, ti, to;
        logic [BW-1:0] od;
        logic ol, oe;
        beat_t e;

        total = exp_q.size();
        n_out = 0;
        @(negedge clk);
        cfg_tok_in   = TOK_W'(n);
        cfg_prefix   = PFX_W'(p);
        cfg_slices   = SLC_W'(s);
        cfg_mode     = mode;
        cfg_keep_pfx = keep;
        cfg_start    = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check_bit("busy_after_start", busy, 1'b1);
        if (noise) cfg_prefix = PFX_W'(5);

        while (!fin && !aborted && cyc < 30000) begin
            cfg_start     = noise && (exp_q.size() > 1);
            bus.pfx_valid = (pfx_q.size() > 0) && ($urandom_range(99) < vld_pct);
            bus.pfx_data  = (pfx_q.size() > 0) ? pfx_q[0] : '0;
            bus.in_valid  = (in_q.size() > 0) && ($urandom_range(99) < vld_pct);
            bus.in_data   = (in_q.size() > 0) ? in_q[0] : '0;
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            #1;
            if (bus.pfx_ready) pr_seen = 1'b1;
            if (rdy_pct < 100 && bus.out_valid && !bus.out_ready)
                check_bit("in_ready_stalled", bus.in_ready, 1'b0);
            tp = bus.pfx_valid && bus.pfx_ready;
            ti = bus.in_valid && bus.in_ready;
            to = bus.out_valid && bus.out_ready;
            od = bus.out_data;
            ol = bus.out_last;
            oe = bus.out_end;
            @(posedge clk);
            #1;
            if (tp) void'(pfx_q.pop_front());
            if (ti) void'(in_q.pop_front());
            if (cfg_err) err_seen = 1'b1;
            if (to) begin
                if (exp_q.size() == 0) begin
                    check_int("extra_out_beat", n_out + 1, total);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", od, e.data);
                    check_bit("out_last", ol, e.last);
                    check_bit("out_end", oe, e.end_);
                    if (e.end_) begin
                        check_bit("done_after_end", done, 1'b1);
                        check_bit("busy_clear_at_done", busy, 1'b0);
                        fin = 1'b1;
                    end
                end
                n_out++;
            end
            if (abort_at >= 0 && n_out == abort_at) aborted = 1'b1;
            @(negedge clk);
            cyc++;
        end

        cfg_start     = 1'b0;
        bus.pfx_valid = 1'b0;
        bus.in_valid  = 1'b0;
        if (!aborted) begin
            check_bit("job_finished", fin, 1'b1);
            check_int("beat_count", n_out, total);
            check_bit("no_cfg_err_while_busy", err_seen, 1'b0);
            if (keep) check_bit("no_pfx_ready_on_reuse", pr_seen, 1'b0);
            @(posedge clk);
            #1;
            check_bit("done_one_cycle", done, 1'b0);
        end
    endtask

    task automatic reject_start(input string tag, input int n, input int p, input int s);
        @(negedge clk);
        cfg_tok_in   = TOK_W'(n);
        cfg_prefix   = PFX_W'(p);
        cfg_slices   = SLC_W'(s);
        cfg_mode     = 1'b0;
        cfg_keep_pfx = 1'b0;
        cfg_start    = 1'b1;
        @(posedge clk);
        #1;
        check_bit({tag, "_err"}, cfg_err, 1'b1);
        check_bit({tag, "_busy"}, busy, 1'b0);
        @(negedge clk);
        cfg_start = 1'b0;
        @(posedge clk);
        #1;
        check_bit({tag, "_err_pulse"}, cfg_err, 1'b0);
        check_bit({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_tok_in    = '0;
        cfg_prefix    = '0;
        cfg_slices    = '0;
        cfg_mode      = 1'b0;
        cfg_keep_pfx  = 1'b0;
        bus.pfx_valid = 1'b0;
        bus.pfx_data  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_cfg_err", cfg_err, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_out_last", bus.out_last, 1'b0);
        check_bit("rst_out_end", bus.out_end, 1'b0);
        check_bit("rst_pfx_ready", bus.pfx_ready, 1'b0);
        check_bit("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // ViT CLS prepend, no backpressure
        prepare(196, 1, 6, 1'b0, 1'b0, 1'b0);
        run_job(196, 1, 6, 1'b0, 1'b0, 100, 100, -1, 1'b0, beats);
        check_int("cls_beats", beats, 1182);

        // Append with patterned prefixes; cfg_start toggled while busy must be ignored
        prepare(5, 2, 3, 1'b1, 1'b0, 1'b1);
        check("append_first_prefix", exp_q[5].data, BW'(32'hA0));
        run_job(5, 2, 3, 1'b1, 1'b0, 100, 100, -1, 1'b1, beats);
        check_int("append_beats", beats, 21);

        // Random backpressure on output and random input gaps
        prepare(196, 1, 6, 1'b0, 1'b0, 1'b0);
        run_job(196, 1, 6, 1'b0, 1'b0, 30, 20, -1, 1'b0, beats);

        // Rejected starts, then a valid small job
        reject_start("reject_p5", 4, 5, 1);
        reject_start("reject_s0", 4, 1, 0);
        reject_start("reject_n0", 0, 1, 1);
        reject_start("reject_s9", 4, 1, 9);
        prepare(4, 1, 1, 1'b0, 1'b0, 1'b0);
        run_job(4, 1, 1, 1'b0, 1'b0, 100, 100, -1, 1'b0, beats);
        check_int("after_reject_beats", beats, 5);

        // Prefix reuse: job B keeps job A's buffer and switches to append
        prepare(3, 2, 2, 1'b0, 1'b0, 1'b0);
        run_job(3, 2, 2, 1'b0, 1'b0, 70, 80, -1, 1'b0, beats);
        prepare(2, 2, 2, 1'b1, 1'b1, 1'b0);
        run_job(2, 2, 2, 1'b1, 1'b1, 100, 100, -1, 1'b0, beats);
        check_int("reuse_beats", beats, 8);

        // No prefix: EMIT skipped entirely, append mode
        prepare(3, 0, 2, 1'b1, 1'b0, 1'b0);
        run_job(3, 0, 2, 1'b1, 1'b0, 100, 100, -1, 1'b0, beats);
        check_int("no_prefix_beats", beats, 6);

        // Reset during slice 2 input phase, then a full job
        prepare(196, 1, 6, 1'b0, 1'b0, 1'b0);
        run_job(196, 1, 6, 1'b0, 1'b0, 100, 100, 400, 1'b0, beats);
        check_bit("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("abort_out_valid", bus.out_valid, 1'b0);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        prepare(196, 1, 6, 1'b0, 1'b0, 1'b0);
        run_job(196, 1, 6, 1'b0, 1'b0, 100, 100, -1, 1'b0, beats);
        check_int("post_abort_beats", beats, 1182);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
